// File: rtl/simon_pkg.sv
// Constants shared by the Simon flash-bits display and the input checker:
// FSM state encoding, LED codes and the button-to-bit mapping.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } simon_state_e;

  localparam logic [1:0] LED_RIGHT = 2'b01;
  localparam logic [1:0] LED_LEFT  = 2'b10;
  localparam logic [1:0] LED_OFF   = 2'b00;

  localparam logic BIT_RIGHT = 1'b1;
  localparam logic BIT_LEFT  = 1'b0;

  // Exactly one held button lights its LED; none or both shows off.
  function automatic logic [1:0] led_code(input logic left, input logic right);
    logic [1:0] code;
    case ({left, right})
      2'b01:   code = LED_RIGHT;
      2'b10:   code = LED_LEFT;
      default: code = LED_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/simon_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples; no backpressure.
module simon_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the count, so a
  // bouncing input never accumulates DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/simon_input_checker.sv
// Simon receive side: decodes debounced presses and checks them against bit_gen[bit_count:0].
// Result registers the edge after a press pulse; SIMON_INPUT_TIMEOUT_EN adds a press timeout.
module simon_input_checker
  import simon_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [27:0] TIMEOUT_CYCLES  = 28'hfffffff
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] bit_count,
  input  logic [7:0] bit_gen,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] led_input,
  output logic       input_done,
  output logic       win
);

  simon_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic         win_q, win_d;
  logic         level_l, level_r, rise_l, rise_r;
  logic         timeout_hit;

  simon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clock(clock), .reset(reset), .raw(btn_left), .level(level_l), .rise(rise_l)
  );

  simon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clock(clock), .reset(reset), .raw(btn_right), .level(level_r), .rise(rise_r)
  );

  // A rise only counts while the other button is released; simultaneous rises
  // are a deliberate mismatch.
  logic both_rise, r_evt, l_evt, press_vld, press_bit, match;
  assign both_rise = rise_l & rise_r;
  assign r_evt     = rise_r & ~level_l;
  assign l_evt     = rise_l & ~level_r;
  assign press_vld = both_rise | r_evt | l_evt;
  assign press_bit = r_evt ? BIT_RIGHT : BIT_LEFT;
  assign match     = ~both_rise & (press_bit == bit_gen[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        win_d = 1'b0;
        if (enable) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (press_vld) begin
          if (match && idx_q == bit_count) begin
            state_d = ST_DONE;
            win_d   = 1'b1;
          end else if (match) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_WAIT_RELEASE;
          end else begin
            state_d = ST_DONE;
            win_d   = 1'b0;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          win_d   = 1'b0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!level_l && !level_r) state_d = ST_WAIT_PRESS;
      end
      default: ;
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      win_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

`ifdef SIMON_INPUT_TIMEOUT_EN
  logic [27:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = (state_q == ST_WAIT_PRESS) && (to_cnt_q == TIMEOUT_CYCLES - 28'd1);

  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_WAIT_PRESS && state_d == ST_WAIT_PRESS) to_cnt_d = to_cnt_q + 28'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  // Without the timeout WAIT_PRESS waits forever; the parameter stays in the interface.
  assign timeout_hit = (TIMEOUT_CYCLES == 28'd0) && 1'b0;
`endif

  assign input_done = (state_q == ST_DONE);
  assign win        = win_q;
  assign led_input  = (state_q == ST_IDLE) ? LED_OFF : led_code(level_l, level_r);

endmodule
